adc_avg_filter: RTL and testbench

Downstream consumer of the R2R SAR converter.
- Captures each completed 8-bit conversion, detected as a rising edge of the converter's valid flag.
- Block-averages 2^LOG2_N conversions into one filtered sample.
- Presents the averaged sample on a valid/ready output, for the 7-segment display driver or a UART framer.
- Tracks an overrun flag if the consumer stalls.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_avg_filter_if.sv | 33 +++
 rtl/rise_detect.sv | 22 ++
 rtl/adc_avg_filter.sv | 163 ++++++++++++++++
 tb/tb_adc_avg_filter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared types for the R2R SAR converter, the averaging filter and
// the display path.
//   ADC_W       - conversion word width
//   adc_word_t  - one conversion result
//   out_state_t - state of the averaged-sample output register
package adc_pkg;

  localparam int ADC_W = 8;

  typedef logic [ADC_W-1:0] adc_word_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

endpackage

// File: rtl/adc_avg_filter_if.sv
// adc_avg_filter_if: averaged-sample output channel of adc_avg_filter.
//   avg_valid - averaged sample available (source -> sink)
//   avg_ready - sink accepts avg_data this cycle (sink -> source)
//   avg_data  - averaged sample (source -> sink)
//   blk_min / blk_max - block minimum / maximum, present only when
//                       ADC_AVG_MINMAX_EN is defined
//
// Handshake: a transfer happens on every rising clk edge where avg_valid and
// avg_ready are both high. While avg_valid is high the source holds avg_data
// (and blk_min/blk_max) stable until that transfer, except when a newer block
// overwrites it, which the source reports as overrun. avg_ready may be high
// without avg_valid and has no effect then.
interface adc_avg_filter_if #(
  parameter int ADC_W = adc_pkg::ADC_W
);

  logic             avg_valid;
  logic             avg_ready;
  logic [ADC_W-1:0] avg_data;
`ifdef ADC_AVG_MINMAX_EN
  logic [ADC_W-1:0] blk_min;
  logic [ADC_W-1:0] blk_max;

  modport master (output avg_valid, output avg_data, output blk_min,
                  output blk_max, input avg_ready);
  modport slave  (input avg_valid, input avg_data, input blk_min,
                  input blk_max, output avg_ready);
`else
  modport master (output avg_valid, output avg_data, input avg_ready);
  modport slave  (input avg_valid, input avg_data, output avg_ready);
`endif

endinterface

// File: rtl/rise_detect.sv
// rise_detect: rising-edge pulse generator with a registered history bit.
//   clk     - clock
//   rst_n   - asynchronous active-low reset (history bit cleared)
//   d_i     - level input
//   pulse_o - high for one cycle when d_i is high and was low last cycle
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/adc_avg_filter.sv
// adc_avg_filter: block-averages 2^LOG2_N converter results into one sample.
// Optional feature macro: ADC_AVG_MINMAX_EN (adds per-block blk_min/blk_max).
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   clear      - synchronous flush of accumulator, output register, overrun
//   adc_valid  - converter done flag (may be held; one capture per rise)
//   adc_result - converter result, stable while adc_valid is high
//   avg        - averaged-sample output channel (master side)
//   sample_cnt - conversions accumulated in the current block
//   overrun    - sticky: a completed average was overwritten unaccepted
//   state_dbg  - output register state, for observation
module adc_avg_filter
  import adc_pkg::*;
#(
  parameter int LOG2_N = 2,
  parameter int ADC_W  = adc_pkg::ADC_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  adc_valid,
  input  logic [ADC_W-1:0]      adc_result,
  adc_avg_filter_if.master      avg,
  output logic [LOG2_N:0]       sample_cnt,
  output logic                  overrun,
  output out_state_t            state_dbg
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  logic             evt;
  logic             complete;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;
  out_state_t       state_q, state_d;

  rise_detect u_rise (
    .clk     (clk),
    .rst_n   (reset_n),
    .d_i     (adc_valid),
    .pulse_o (evt)
  );

  // The accumulator holds at most N-1 results, so adding one more cannot
  // exceed ADC_W+LOG2_N bits.
  assign sum      = acc_q + ACC_W'(adc_result);
  assign complete = evt && (cnt_q == CNT_LAST);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    state_d   = state_q;
    if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      data_d    = '0;
      overrun_d = 1'b0;
      state_d   = OUT_EMPTY;
    end else begin
      if (complete) begin
        acc_d  = '0;
        cnt_d  = '0;
        data_d = ADC_W'(sum >> LOG2_N);
      end else if (evt) begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        OUT_EMPTY: begin
          if (complete) state_d = OUT_FULL;
        end
        OUT_FULL: begin
          // A completion while full replaces the data; it is only an overrun
          // when the old sample is not being accepted in the same cycle.
          if (complete) begin
            state_d = OUT_FULL;
            if (!avg.avg_ready) overrun_d = 1'b1;
          end else if (avg.avg_ready) begin
            state_d = OUT_EMPTY;
          end
        end
        default: state_d = OUT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      state_q   <= OUT_EMPTY;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [ADC_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [ADC_W-1:0] blk_min_q, blk_min_d, blk_max_q, blk_max_d;
  logic [ADC_W-1:0] min_nx, max_nx;
  logic             first;

  // The first capture of a block re-seeds both trackers.
  assign first  = (cnt_q == '0);
  assign min_nx = (first || (adc_result < run_min_q)) ? adc_result : run_min_q;
  assign max_nx = (first || (adc_result > run_max_q)) ? adc_result : run_max_q;

  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    blk_min_d = blk_min_q;
    blk_max_d = blk_max_q;
    if (clear) begin
      blk_min_d = '0;
      blk_max_d = '0;
    end else if (evt) begin
      run_min_d = min_nx;
      run_max_d = max_nx;
      if (complete) begin
        blk_min_d = min_nx;
        blk_max_d = max_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_min_q <= '0;
      run_max_q <= '0;
      blk_min_q <= '0;
      blk_max_q <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      blk_min_q <= blk_min_d;
      blk_max_q <= blk_max_d;
    end
  end

  assign avg.blk_min = blk_min_q;
  assign avg.blk_max = blk_max_q;
`endif

  assign avg.avg_valid = (state_q == OUT_FULL);
  assign avg.avg_data  = data_q;
  assign sample_cnt    = cnt_q;
  assign overrun       = overrun_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// tb_adc_avg_filter: directed bench for adc_avg_filter, LOG2_N=2 and LOG2_N=0.
module tb_adc_avg_filter;
  import adc_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with LOG2_N = 2 ----------------
  logic         clear2 = 1'b0;
  logic         v2 = 1'b0;
  logic [W-1:0] r2 = '0;
  logic [2:0]   cnt2;
  logic         ovr2;
  out_state_t   st2;
  adc_avg_filter_if #(.ADC_W(W)) if2 ();

  adc_avg_filter #(.LOG2_N(2), .ADC_W(W)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear2),
    .adc_valid  (v2),
    .adc_result (r2),
    .avg        (if2),
    .sample_cnt (cnt2),
    .overrun    (ovr2),
    .state_dbg  (st2)
  );

  // ---------------- DUT with LOG2_N = 0 ----------------
  logic         clear0 = 1'b0;
  logic         v0 = 1'b0;
  logic [W-1:0] r0 = '0;
  logic [0:0]   cnt0;
  logic         ovr0;
  out_state_t   st0;
  adc_avg_filter_if #(.ADC_W(W)) if0 ();

  adc_avg_filter #(.LOG2_N(0), .ADC_W(W)) dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear0),
    .adc_valid  (v0),
    .adc_result (r0),
    .avg        (if0),
    .sample_cnt (cnt0),
    .overrun    (ovr0),
    .state_dbg  (st0)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp0_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every accepted output is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && if2.avg_valid && if2.avg_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dut2_unexpected_output: got %0d expected none", if2.avg_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (if2.avg_data !== e) begin
          errors++;
          $display("FAIL dut2_avg_data: got %0d expected %0d", if2.avg_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && if0.avg_valid && if0.avg_ready) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_output: got %0d expected none", if0.avg_data);
      end else begin
        logic [W-1:0] e;
        e = exp0_q.pop_front();
        if (if0.avg_data !== e) begin
          errors++;
          $display("FAIL dut0_avg_data: got %0d expected %0d", if0.avg_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One low cycle, then adc_valid high for len edges; returns 1 after the
  // last high edge (1 after the capturing edge when len=1).
  task automatic pulse2(input logic [W-1:0] val, input int len);
    step();
    v2 = 1'b1;
    r2 = val;
    repeat (len) step();
    v2 = 1'b0;
  endtask

  task automatic pulse0(input logic [W-1:0] val);
    step();
    v0 = 1'b1;
    r0 = val;
    step();
    v0 = 1'b0;
  endtask

  task automatic block2(input logic [W-1:0] val);
    repeat (4) pulse2(val, 1);
  endtask

  task automatic clear_dut2();
    step();
    clear2 = 1'b1;
    step();
    clear2 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if2.avg_ready = 1'b1;
    if0.avg_ready = 1'b1;
    #22;
    // reset state
    check("reset_avg_valid", if2.avg_valid, 0);
    check("reset_avg_data", if2.avg_data, 0);
    check("reset_sample_cnt", cnt2, 0);
    check("reset_overrun", ovr2, 0);
    reset_n = 1'b1;
    step();

    // averaging: (10+20+30+41)>>2 = 25
    exp_q.push_back(8'd25);
    pulse2(8'd10, 1); check("avg_cnt_1", cnt2, 1);
    pulse2(8'd20, 1); check("avg_cnt_2", cnt2, 2);
    pulse2(8'd30, 1); check("avg_cnt_3", cnt2, 3);
    pulse2(8'd41, 1); check("avg_cnt_wrap", cnt2, 0);
    check("avg_valid_latency", if2.avg_valid, 1);
    check("avg_data_25", if2.avg_data, 25);
    step();
    check("avg_valid_one_cycle", if2.avg_valid, 0);

    // long valid: one capture per assertion
    exp_q.push_back(8'd200);
    pulse2(8'd200, 5); check("long_cnt_1", cnt2, 1);
    repeat (3) pulse2(8'd200, 5);
    check("long_cnt_wrap", cnt2, 0);
    check("long_avg_data", if2.avg_data, 200);

    // stall / overrun: block of 8s overwritten by block of 16s
    step();
    if2.avg_ready = 1'b0;
    exp_q.push_back(8'd16);
    block2(8'd8);
    check("stall_no_overrun_yet", ovr2, 0);
    block2(8'd16);
    check("stall_avg_data", if2.avg_data, 16);
    check("stall_overrun", ovr2, 1);
    check("stall_state", st2, OUT_FULL);
    if2.avg_ready = 1'b1;
    step();
    if2.avg_ready = 1'b0;
    check("stall_valid_drop", if2.avg_valid, 0);
    check("stall_overrun_sticky", ovr2, 1);
    clear_dut2();
    check("clear_overrun", ovr2, 0);

    // handshake coincident with completion
    exp_q.push_back(8'd40);
    exp_q.push_back(8'd50);
    block2(8'd40);
    check("coinc_first_full", if2.avg_valid, 1);
    repeat (3) pulse2(8'd50, 1);
    step();
    v2 = 1'b1;
    r2 = 8'd50;
    if2.avg_ready = 1'b1;
    step();
    v2 = 1'b0;
    if2.avg_ready = 1'b0;
    check("coinc_valid_stays", if2.avg_valid, 1);
    check("coinc_avg_data", if2.avg_data, 50);
    check("coinc_no_overrun", ovr2, 0);
    if2.avg_ready = 1'b1;
    step();
    check("coinc_drained", if2.avg_valid, 0);

    // clear concurrent with a valid edge mid-block
    pulse2(8'd100, 1);
    pulse2(8'd100, 1);
    check("clr_pre_cnt", cnt2, 2);
    step();
    clear2 = 1'b1;
    v2 = 1'b1;
    r2 = 8'd100;
    step();
    clear2 = 1'b0;
    check("clr_cnt", cnt2, 0);
    check("clr_avg_valid", if2.avg_valid, 0);
    step();
    check("clr_no_recapture", cnt2, 0);
    v2 = 1'b0;
    exp_q.push_back(8'd60);
    block2(8'd60);
    check("clr_acc_emptied", if2.avg_data, 60);

    // asynchronous reset mid-block
    step();
    if2.avg_ready = 1'b0;
    block2(8'd12);
    block2(8'd12);
    pulse2(8'd5, 1);
    pulse2(8'd5, 1);
    check("rst_pre_valid", if2.avg_valid, 1);
    check("rst_pre_overrun", ovr2, 1);
    check("rst_pre_cnt", cnt2, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", if2.avg_valid, 0);
    check("rst_async_data", if2.avg_data, 0);
    check("rst_async_cnt", cnt2, 0);
    check("rst_async_overrun", ovr2, 0);
    step();
    reset_n = 1'b1;
    if2.avg_ready = 1'b1;

    // pass-through, LOG2_N = 0
    exp0_q.push_back(8'd0);
    pulse0(8'd0);
    check("pt_valid_0", if0.avg_valid, 1);
    check("pt_data_0", if0.avg_data, 0);
    check("pt_cnt_0", cnt0, 0);
    exp0_q.push_back(8'd255);
    pulse0(8'd255);
    check("pt_data_255", if0.avg_data, 255);
    check("pt_cnt_255", cnt0, 0);

`ifdef ADC_AVG_MINMAX_EN
    // min/max: 7,3,9,5 -> avg 6, min 3, max 9
    step();
    if2.avg_ready = 1'b0;
    exp_q.push_back(8'd6);
    pulse2(8'd7, 1);
    pulse2(8'd3, 1);
    pulse2(8'd9, 1);
    pulse2(8'd5, 1);
    check("mm_avg_data", if2.avg_data, 6);
    check("mm_blk_min", if2.blk_min, 3);
    check("mm_blk_max", if2.blk_max, 9);
    if2.avg_ready = 1'b1;
    step();
`endif

    // drain, bounded
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && exp0_q.size() == 0) break;
      step();
    end
    check("dut2_queue_drained", exp_q.size(), 0);
    check("dut0_queue_drained", exp0_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
